// File: rtl/blockade_vram_arbiter_pkg.sv
// Shared constants and FSM encoding for the Blockade video RAM arbiter.
package blockade_pkg;

  localparam int VRAM_ADDR_W = 10;
  localparam int VRAM_DATA_W = 8;
  // Clocks from vid_req to vid_valid on an idle arbiter; the video chain
  // delays the PROM address by this much to line up with the character code.
  localparam int VID_LAT     = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VID_RD   = 3'd1,
    VID_CAP  = 3'd2,
    CPU_ACC  = 3'd3,
    CPU_CAP  = 3'd4,
    CPU_DONE = 3'd5
  } arb_state_e;

endpackage

// File: rtl/blockade_vram_arbiter.sv
// Single-port VRAM arbiter: video character fetches have hard priority, the
// 8080 is stalled through READY until it gets a slot (optionally blank only).
module blockade_vram_arbiter
  import blockade_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter bit BLANK_ONLY = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              blank,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              overrun
);

  arb_state_e        state_q, state_d;
  logic              vid_pend_q, vid_pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              overrun_q, overrun_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic slot_free, vid_go, cpu_grant, cpu_done;

  // The port is free in IDLE, and also in CPU_DONE once the CPU lets go, so a
  // fetch that queued up during a CPU op starts without an extra IDLE clock.
  assign slot_free = (state_q == IDLE) || ((state_q == CPU_DONE) && !cpu_req);
  assign vid_go    = slot_free && (vid_req || vid_pend_q);
  assign cpu_grant = (state_q == IDLE) && cpu_req && !vid_req && !vid_pend_q &&
                     (blank || !BLANK_ONLY);
  assign cpu_done  = (state_q == CPU_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (vid_go) state_d = VID_RD;
                else if (cpu_grant) state_d = CPU_ACC;
      VID_RD:   state_d = VID_CAP;
      VID_CAP:  state_d = IDLE;
      // ram_we_q doubles as the latched write flag for the granted op
      CPU_ACC:  state_d = ram_we_q ? CPU_DONE : CPU_CAP;
      CPU_CAP:  state_d = CPU_DONE;
      CPU_DONE: if (!cpu_req) state_d = vid_go ? VID_RD : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    vid_data_d  = vid_data_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_valid_d = (state_q == VID_CAP);
    if (vid_go) begin
      ram_addr_d = vid_pend_q ? pend_addr_q : vid_addr;
    end else if (cpu_grant) begin
      ram_addr_d  = cpu_addr;
      ram_wdata_d = cpu_wdata;
      ram_we_d    = cpu_we;
    end
    if (state_q == VID_CAP) vid_data_d  = ram_rdata;
    if (state_q == CPU_CAP) cpu_rdata_d = ram_rdata;
    // One-deep pending slot; a request that finds it occupied is lost.
    vid_pend_d  = vid_go ? (vid_pend_q && vid_req) : (vid_pend_q || vid_req);
    pend_addr_d = (vid_req && (vid_go ? vid_pend_q : !vid_pend_q)) ? vid_addr : pend_addr_q;
    overrun_d   = overrun_q || (vid_req && vid_pend_q && !vid_go);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_pend_q  <= 1'b0;
      pend_addr_q <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
      overrun_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      vid_pend_q  <= vid_pend_d;
      pend_addr_q <= pend_addr_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      cpu_rdata_q <= cpu_rdata_d;
      overrun_q   <= overrun_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign vid_data  = vid_data_q;
  assign vid_valid = vid_valid_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = !cpu_req || cpu_done;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign overrun   = overrun_q;

endmodule
